// File: rtl/chacha_pkg.sv
// Shared ChaCha types, constants and quarter-round index tables for the block engine.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] chacha_state_t;

  localparam word_t CHACHA_CONST [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  // Row q lists the (a,b,c,d) word indices of quarter-round q within a column or diagonal round.
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };
  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_ADD   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  function automatic word_t rotl32(word_t v, int unsigned s);
    return (v << s) | (v >> (32 - s));
  endfunction

endpackage

// File: rtl/chacha_qround.sv
// One ChaCha quarter-round, purely combinational.
module chacha_qround
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_nxt,
  output word_t b_nxt,
  output word_t c_nxt,
  output word_t d_nxt
);

  word_t a1, b1, c1, d1, a2, b2, c2, d2;

  always_comb begin
    a1 = a + b;
    d1 = rotl32(d ^ a1, 16);
    c1 = c + d1;
    b1 = rotl32(b ^ c1, 12);
    a2 = a1 + b1;
    d2 = rotl32(d1 ^ a2, 8);
    c2 = c1 + d2;
    b2 = rotl32(b1 ^ c2, 7);
  end

  assign a_nxt = a2;
  assign b_nxt = b2;
  assign c_nxt = c2;
  assign d_nxt = d2;

endmodule

// File: rtl/chacha_block_engine.sv
// ChaCha keystream block generator: QR_PAR quarter-rounds per clock, counter
// auto-increment across a multi-block request, valid/ready on both sides.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int QR_PAR = 1,
  parameter int BLK_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [255:0]       key,
  input  logic [95:0]        nonce,
  input  logic [31:0]        counter_init,
  input  logic [BLK_W-1:0]   num_blocks,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [511:0]       out_block,
  output logic [31:0]        out_counter,
  output logic               out_last,
  output logic               ctr_ovf,
  output logic               busy
);

  localparam int GRP   = 4 / QR_PAR;
  localparam int N     = ROUNDS * GRP;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_QR = CNT_W'(N - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] qr_cnt;
  word_t            counter;
  logic [BLK_W-1:0] remaining;
  logic [255:0]     key_q;
  logic [95:0]      nonce_q;
  chacha_state_t    init_state, work_state, round_nxt, sum_state;

  logic             odd_round;
  logic [1:0]       grp_base;
  logic [3:0]       widx [QR_PAR][4];
  word_t            qin  [QR_PAR][4];
  word_t            qout [QR_PAR][4];

  function automatic chacha_state_t make_state(logic [255:0] k, logic [95:0] n, word_t ctr);
    chacha_state_t s;
    for (int i = 0; i < 4; i++) s[i] = CHACHA_CONST[i];
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
    return s;
  endfunction

  // qr_cnt walks GRP groups per round; the group picks which QR_PAR quarter-rounds run this cycle.
  always_comb begin
    odd_round = ((int'(qr_cnt) / GRP) % 2) != 0;
    grp_base  = 2'((int'(qr_cnt) % GRP) * QR_PAR);
    for (int p = 0; p < QR_PAR; p++) begin
      for (int k = 0; k < 4; k++) begin
        widx[p][k] = odd_round ? DIAG_IDX[grp_base + 2'(p)][k] : COL_IDX[grp_base + 2'(p)][k];
        qin[p][k]  = work_state[widx[p][k]];
      end
    end
  end

  for (genvar p = 0; p < QR_PAR; p++) begin : g_qr
    chacha_qround u_qr (
      .a     (qin[p][0]),
      .b     (qin[p][1]),
      .c     (qin[p][2]),
      .d     (qin[p][3]),
      .a_nxt (qout[p][0]),
      .b_nxt (qout[p][1]),
      .c_nxt (qout[p][2]),
      .d_nxt (qout[p][3])
    );
  end

  always_comb begin
    round_nxt = work_state;
    for (int p = 0; p < QR_PAR; p++) begin
      for (int k = 0; k < 4; k++) round_nxt[widx[p][k]] = qout[p][k];
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) sum_state[i] = init_state[i] + work_state[i];
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      qr_cnt      <= '0;
      counter     <= '0;
      remaining   <= '0;
      out_valid   <= 1'b0;
      out_block   <= '0;
      out_counter <= '0;
      out_last    <= 1'b0;
      ctr_ovf     <= 1'b0;
    end else begin
      ctr_ovf <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            counter   <= counter_init;
            remaining <= num_blocks;
            if (num_blocks != '0) state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          qr_cnt <= '0;
          state  <= ST_ROUND;
        end
        ST_ROUND: begin
          qr_cnt <= qr_cnt + 1'b1;
          if (qr_cnt == LAST_QR) state <= ST_ADD;
        end
        ST_ADD: begin
          out_block   <= sum_state;
          out_counter <= counter;
          out_last    <= (remaining == BLK_W'(1)) || (counter == 32'hFFFF_FFFF);
          out_valid   <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              // Final block reached through counter wrap while blocks were still owed.
              ctr_ovf <= (remaining != BLK_W'(1));
              state   <= ST_IDLE;
            end else begin
              counter   <= counter + 32'd1;
              remaining <= remaining - 1'b1;
              state     <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      key_q   <= key;
      nonce_q <= nonce;
    end
    if (state == ST_LOAD) begin
      init_state <= make_state(key_q, nonce_q, counter);
      work_state <= make_state(key_q, nonce_q, counter);
    end else if (state == ST_ROUND) begin
      work_state <= round_nxt;
    end
  end

endmodule

// File: doc/chacha_block_engine.md
Name: chacha_block_engine

Overview:
Parametrised successor to the ChaCha quarter-round sequencer. The block takes a key, a nonce, a start counter and a block count, and produces that many keystream blocks.
- Each block is the full ChaCha state after ROUNDS rounds, with the feed-forward addition of the initial state.
- The counter auto-increments between blocks.
- Has a valid/ready handshake on both input and output.
- Sits between the AEAD controller (request side) and the XOR/Poly1305-key datapath (keystream side).

Parameters:
ROUNDS, 20, total rounds (even, >=2; 8/12/20 = ChaCha8/12/20)
QR_PAR, 1, quarter-rounds evaluated per clk (legal 1, 2, 4)
BLK_W, 8, width of num_blocks

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  engine can accept request (high only in IDLE)
key  in  256  key; word i = key[32*i+:32]
nonce  in  96  nonce; word i = nonce[32*i+:32]
counter_init  in  32  block counter of first block
num_blocks  in  BLK_W  blocks to generate
out_valid  out  1  out_block valid
out_ready  in  1  consumer accepts block
out_block  out  512  keystream state; word i = out_block[32*i+:32]
out_counter  out  32  counter value used for out_block
out_last  out  1  this is the final block of the request
ctr_ovf  out  1  one-cycle pulse: request truncated by counter wrap
busy  out  1  not IDLE

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; in_ready=1; out_valid=0; out_block=0; out_counter=0; out_last=0; ctr_ovf=0; busy=0.
  - An in-flight request is discarded.
- State layout: words 0-3 = 61707865, 3320646e, 79622d32, 6b206574; words 4-11 = key; word 12 = counter; words 13-15 = nonce. Matrix element [r][c] = word 4r+c.
- Round r even = column round, QRs (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15). Round r odd = diagonal round, QRs (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
- Each QR:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- All additions are mod 2^32.
- Each clk applies QR_PAR quarter-rounds from the same round (word-disjoint). N = ROUNDS*4/QR_PAR round cycles per block.
- FSM:
  - IDLE: in_valid&&in_ready -> latch key, nonce, counter_init and num_blocks. If num_blocks==0 -> stay IDLE, no output. Else -> LOAD.
  - LOAD (1 cycle): init_state and work_state <= state(counter); qr_cnt=0 -> ROUND.
  - ROUND (N cycles): apply QR group, qr_cnt++. On last group -> ADD.
  - ADD (1 cycle): out_block <= init_state+work_state wordwise; out_counter <= counter; out_last <= (remaining==1) || (counter==FFFFFFFF); out_valid <= 1 -> HOLD.
  - HOLD: out_block, out_counter and out_last are held stable while !out_ready. On out_valid&&out_ready:
    - out_valid <= 0.
    - If out_last -> IDLE. Else counter++, remaining-- -> LOAD.
- Latency: request accepted at edge 0 -> out_valid high after edge N+2. Each subsequent block appears N+2 edges after the previous output handshake. ROUNDS=20, QR_PAR=1 -> 82.
- Counter wrap: a block with counter FFFFFFFF is always the last block. If blocks remained, ctr_ovf pulses 1 cycle on that block's output handshake. The counter never wraps to 0 within a request.
- in_valid while busy: ignored (in_ready=0). Latched inputs are unaffected by input changes mid-request.
- out_ready high with out_valid low: no effect.

Decomposition:
- Package chacha_pkg:
  - word_t (32-bit)
  - chacha_state_t (word_t [15:0])
  - CHACHA_CONST[4]
  - QR index tables COL_IDX/DIAG_IDX [4][4]
  - function rotl32
- Sub-module chacha_qround: purely combinational single QR, (a,b,c,d) in -> (a,b,c,d) out. It is instantiated QR_PAR times, with index muxing selected by round parity and qr_cnt.

Test Plan:
1. Reset mid-ROUND -> out_valid=0 and busy=0 immediately; in_ready=1 after release; a fresh request then produces correct output.
2. RFC 8439 2.3.2 vector, QR_PAR=1/2/4. Stimulus: key bytes 00..1f, nonce words 09000000, 4a000000, 00000000; counter_init=1; num_blocks=1; out_ready=1.
   - Required: out_block word0=e4e7f110, word1=15593bd1, word15=4e3c50a2.
   - out_last=1, out_counter=1.
   - out_valid at edge 82/42/22 respectively.
3. num_blocks=3, counter_init=7; out_ready low for 10 cycles on block 2.
   - Required: out_counter sequence 7, 8, 9.
   - Block 2 is held unchanged during the stall.
   - out_last only on counter 9; back to IDLE after.
4. counter_init=FFFFFFFE, num_blocks=4 -> two blocks (FFFFFFFE, FFFFFFFF); out_last on the second; ctr_ovf pulses exactly once.
5. num_blocks=0 -> accepted, no out_valid for 200 cycles, in_ready stays 1.
6. ROUNDS=8 with RFC key/nonce -> matches a software ChaCha8 model; in_valid asserted while busy with a different key does not perturb the output.
